// File: rtl/round_sequencer.sv
// Game-round controller: sequences attract/ready/play/clear/death/over, scores
// collected flags from the flag display mask and tracks level and lives.
module round_sequencer #(
    parameter int NUM_FLAGS    = 5,
    parameter int START_LIVES  = 3,
    parameter int READY_FRAMES = 120,
    parameter int CLEAR_FRAMES = 90,
    parameter int DEATH_FRAMES = 60,
    parameter int OVER_FRAMES  = 180,
    parameter int FLAG_POINTS  = 100,
    parameter int CLEAR_BONUS  = 1000,
    parameter int SCORE_W      = 16,
    parameter int MAX_LEVEL    = 15
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 frame_tick,
    input  logic                 start_btn,
    input  logic [NUM_FLAGS-1:0] flagDisplay,
    input  logic                 crash,
    input  logic                 fuel_empty,
    output logic                 flagReset,
    output logic                 play_enable,
    output logic [2:0]           state,
    output logic [3:0]           level,
    output logic [1:0]           lives,
    output logic [SCORE_W-1:0]   score,
    output logic                 game_over
);

    localparam int SUM_W = SCORE_W + 8;
    localparam int CNT_W = $clog2(NUM_FLAGS + 1);

    typedef enum logic [2:0] {
        ST_ATTRACT = 3'd0,
        ST_READY   = 3'd1,
        ST_PLAY    = 3'd2,
        ST_CLEAR   = 3'd3,
        ST_DEATH   = 3'd4,
        ST_OVER    = 3'd5
    } state_t;

    state_t               r_state;
    logic [7:0]           r_cnt;
    logic [NUM_FLAGS-1:0] r_prev;
    logic [SCORE_W-1:0]   r_score;
    logic [3:0]           r_level;
    logic [1:0]           r_lives;
    logic                 r_flag_reset;
    logic                 r_play_enable;
    logic                 r_game_over;

    logic [NUM_FLAGS-1:0] w_fall;
    logic [CNT_W-1:0]     w_pop;
    logic [SUM_W-1:0]     w_flag_pts;
    logic [SCORE_W-1:0]   w_score_flags;
    logic [SCORE_W-1:0]   w_score_clear;
    logic [7:0]           w_limit;
    logic                 w_expire;
    logic [3:0]           w_level_next;

    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_FLAGS-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_FLAGS; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    // Sums are formed wide enough never to wrap, then clamped to the score range.
    function automatic logic [SCORE_W-1:0] sat_score(input logic [SUM_W-1:0] v);
        if (|v[SUM_W-1:SCORE_W]) begin
            return '1;
        end
        return v[SCORE_W-1:0];
    endfunction

    assign w_fall        = r_prev & ~flagDisplay;
    assign w_pop         = popcount(w_fall);
    assign w_flag_pts    = SUM_W'(w_pop) * SUM_W'(FLAG_POINTS) * SUM_W'({1'b0, r_level} + 5'd1);
    assign w_score_flags = sat_score(SUM_W'(r_score) + w_flag_pts);
    assign w_score_clear = sat_score(SUM_W'(r_score) + w_flag_pts + SUM_W'(CLEAR_BONUS));
    assign w_level_next  = (r_level >= 4'(MAX_LEVEL)) ? 4'(MAX_LEVEL) : r_level + 4'd1;

    always_comb begin
        w_limit = 8'd0;
        case (r_state)
            ST_READY: w_limit = 8'(READY_FRAMES - 1);
            ST_CLEAR: w_limit = 8'(CLEAR_FRAMES - 1);
            ST_DEATH: w_limit = 8'(DEATH_FRAMES - 1);
            ST_OVER:  w_limit = 8'(OVER_FRAMES - 1);
            default:  w_limit = 8'd0;
        endcase
    end

    assign w_expire = frame_tick && (r_cnt == w_limit);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state       <= ST_ATTRACT;
            r_cnt         <= 8'd0;
            r_prev        <= '1;
            r_score       <= '0;
            r_level       <= 4'd0;
            r_lives       <= 2'(START_LIVES);
            r_flag_reset  <= 1'b0;
            r_play_enable <= 1'b0;
            r_game_over   <= 1'b0;
        end else begin
            r_prev       <= flagDisplay;
            r_flag_reset <= 1'b0;
            if (frame_tick) begin
                r_cnt <= r_cnt + 8'd1;
            end
            case (r_state)
                ST_ATTRACT: begin
                    if (start_btn) begin
                        r_state      <= ST_READY;
                        r_cnt        <= 8'd0;
                        r_score      <= '0;
                        r_level      <= 4'd0;
                        r_lives      <= 2'(START_LIVES);
                        r_flag_reset <= 1'b1;
                    end
                end
                ST_READY: begin
                    if (w_expire) begin
                        r_state       <= ST_PLAY;
                        r_cnt         <= 8'd0;
                        r_play_enable <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    // An empty field wins over a simultaneous crash or fuel-out.
                    if (flagDisplay == '0) begin
                        r_state       <= ST_CLEAR;
                        r_cnt         <= 8'd0;
                        r_score       <= w_score_clear;
                        r_play_enable <= 1'b0;
                    end else begin
                        r_score <= w_score_flags;
                        if (crash || fuel_empty) begin
                            r_state       <= ST_DEATH;
                            r_cnt         <= 8'd0;
                            r_play_enable <= 1'b0;
                        end
                    end
                end
                ST_CLEAR: begin
                    if (w_expire) begin
                        r_state      <= ST_READY;
                        r_cnt        <= 8'd0;
                        r_level      <= w_level_next;
                        r_flag_reset <= 1'b1;
                    end
                end
                ST_DEATH: begin
                    if (w_expire) begin
                        r_cnt <= 8'd0;
                        if (r_lives <= 2'd1) begin
                            r_state     <= ST_OVER;
                            r_lives     <= 2'd0;
                            r_game_over <= 1'b1;
                        end else begin
                            r_state <= ST_READY;
                            r_lives <= r_lives - 2'd1;
                        end
                    end
                end
                ST_OVER: begin
                    if (w_expire) begin
                        r_state     <= ST_ATTRACT;
                        r_cnt       <= 8'd0;
                        r_game_over <= 1'b0;
                    end
                end
                default: begin
                    r_state       <= ST_ATTRACT;
                    r_cnt         <= 8'd0;
                    r_play_enable <= 1'b0;
                    r_game_over   <= 1'b0;
                end
            endcase
        end
    end

    assign state       = r_state;
    assign score       = r_score;
    assign level       = r_level;
    assign lives       = r_lives;
    assign flagReset   = r_flag_reset;
    assign play_enable = r_play_enable;
    assign game_over   = r_game_over;

endmodule

// File: tb/tb_round_sequencer.sv
// Scoreboard bench for round_sequencer: expectations are queued per driven
// cycle and compared against all outputs once the DUT has clocked.
module tb_round_sequencer;

    logic        Clk;
    logic        Reset;
    logic        frame_tick;
    logic        start_btn;
    logic [4:0]  flagDisplay;
    logic        crash;
    logic        fuel_empty;
    logic        flagReset;
    logic        play_enable;
    logic [2:0]  state;
    logic [3:0]  level;
    logic [1:0]  lives;
    logic [15:0] score;
    logic        game_over;

    int n_vec;
    int n_err;
    int e_score;
    int e_level;
    int e_lives;

    typedef struct {
        string       tag;
        logic [2:0]  st;
        logic [15:0] sc;
        logic [3:0]  lv;
        logic [1:0]  li;
        logic        fr;
    } exp_t;

    exp_t sb_q[$];

    round_sequencer dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_tick  (frame_tick),
        .start_btn   (start_btn),
        .flagDisplay (flagDisplay),
        .crash       (crash),
        .fuel_empty  (fuel_empty),
        .flagReset   (flagReset),
        .play_enable (play_enable),
        .state       (state),
        .level       (level),
        .lives       (lives),
        .score       (score),
        .game_over   (game_over)
    );

    always #5 Clk = ~Clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic push_exp(input string tag, input int st, input bit fr);
        exp_t e;
        e.tag = tag;
        e.st  = 3'(st);
        e.sc  = 16'(e_score);
        e.lv  = 4'(e_level);
        e.li  = 2'(e_lives);
        e.fr  = fr;
        sb_q.push_back(e);
    endtask

    task automatic sb_compare();
        exp_t e;
        e = sb_q.pop_front();
        check_val({e.tag, ".state"}, 32'(state), 32'(e.st));
        check_val({e.tag, ".score"}, 32'(score), 32'(e.sc));
        check_val({e.tag, ".level"}, 32'(level), 32'(e.lv));
        check_val({e.tag, ".lives"}, 32'(lives), 32'(e.li));
        check_val({e.tag, ".flagReset"}, 32'(flagReset), 32'(e.fr));
        check_val({e.tag, ".play_enable"}, 32'(play_enable), 32'(e.st == 3'd2));
        check_val({e.tag, ".game_over"}, 32'(game_over), 32'(e.st == 3'd5));
    endtask

    task automatic step(input bit tk);
        frame_tick = tk;
        @(posedge Clk);
        #1;
        frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b1);
    endtask

    task automatic go(input bit tk, input string tag, input int st, input bit fr);
        push_exp(tag, st, fr);
        step(tk);
        sb_compare();
    endtask

    task automatic expect_now(input string tag, input int st, input bit fr);
        push_exp(tag, st, fr);
        sb_compare();
    endtask

    // Assumes no ticks since READY was entered; 120th tick moves to PLAY.
    task automatic to_play(input string tag);
        ticks(118);
        go(1'b1, {tag, "_ready_hold"}, 1, 1'b0);
        go(1'b1, tag, 2, 1'b0);
    endtask

    // Assumes no ticks since DEATH was entered; 60th tick leaves it.
    task automatic finish_death(input string tag);
        ticks(58);
        go(1'b1, {tag, "_death_hold"}, 4, 1'b0);
        if (e_lives == 1) begin
            e_lives = 0;
            go(1'b1, tag, 5, 1'b0);
        end else begin
            e_lives = e_lives - 1;
            go(1'b1, tag, 1, 1'b0);
        end
    endtask

    initial begin
        Clk         = 1'b0;
        Reset       = 1'b1;
        frame_tick  = 1'b0;
        start_btn   = 1'b0;
        flagDisplay = 5'b11111;
        crash       = 1'b0;
        fuel_empty  = 1'b0;
        n_vec       = 0;
        n_err       = 0;
        e_score     = 0;
        e_level     = 0;
        e_lives     = 3;

        repeat (2) @(posedge Clk);
        #1;
        expect_now("reset", 0, 1'b0);
        Reset = 1'b0;
        go(1'b0, "attract_idle", 0, 1'b0);

        start_btn = 1'b1;
        go(1'b0, "start", 1, 1'b1);
        go(1'b0, "start_stuck", 1, 1'b0);
        start_btn = 1'b0;
        to_play("play_l0");

        flagDisplay = 5'b11110; e_score = 100;
        go(1'b0, "flag_one", 2, 1'b0);
        flagDisplay = 5'b11000; e_score = 300;
        go(1'b0, "flag_two", 2, 1'b0);
        flagDisplay = 5'b01000; e_score = 400;
        go(1'b0, "flag_three", 2, 1'b0);
        flagDisplay = 5'b00000; crash = 1'b1; e_score = 1500;
        go(1'b0, "last_flag_crash", 3, 1'b0);
        crash = 1'b0;
        ticks(88);
        go(1'b1, "clear_hold", 3, 1'b0);
        e_level = 1;
        go(1'b1, "clear_done", 1, 1'b1);

        flagDisplay = 5'b11111;
        go(1'b0, "ready_l1", 1, 1'b0);
        to_play("play_l1");
        flagDisplay = 5'b11110; e_score = 1700;
        go(1'b0, "l1_flag", 2, 1'b0);
        flagDisplay = 5'b10101; e_score = 2100;
        go(1'b0, "l1_flag_pair", 2, 1'b0);
        fuel_empty = 1'b1;
        go(1'b0, "fuel_death", 4, 1'b0);
        fuel_empty = 1'b0;
        flagDisplay = 5'b00101;
        go(1'b0, "death_fall_ignored", 4, 1'b0);
        finish_death("lives_2");

        to_play("play_l1b");
        crash = 1'b1;
        go(1'b0, "crash_b", 4, 1'b0);
        crash = 1'b0;
        finish_death("lives_1");

        to_play("play_l1c");
        crash = 1'b1;
        go(1'b0, "crash_c", 4, 1'b0);
        crash = 1'b0;
        finish_death("game_over");

        start_btn = 1'b1;
        ticks(178);
        go(1'b1, "over_hold", 5, 1'b0);
        go(1'b1, "over_exit", 0, 1'b0);
        e_score = 0; e_level = 0; e_lives = 3;
        go(1'b0, "restart", 1, 1'b1);
        start_btn = 1'b0;

        for (int k = 0; k < 16; k++) begin
            flagDisplay = 5'b11111;
            to_play("sat_play");
            flagDisplay = 5'b00000;
            e_score = e_score + 500 * (e_level + 1) + 1000;
            if (e_score > 65535) e_score = 65535;
            go(1'b0, "sat_clear", 3, 1'b0);
            ticks(88);
            go(1'b1, "sat_clear_hold", 3, 1'b0);
            e_level = (e_level >= 15) ? 15 : e_level + 1;
            go(1'b1, "sat_next", 1, 1'b1);
        end

        flagDisplay = 5'b11111;
        to_play("final_play");
        flagDisplay = 5'b00000;
        go(1'b0, "final_clear", 3, 1'b0);
        ticks(30);
        #2;
        Reset = 1'b1;
        #1;
        e_score = 0; e_level = 0; e_lives = 3;
        expect_now("reset_mid_clear", 0, 1'b0);
        step(1'b1);
        Reset = 1'b0;
        go(1'b1, "post_reset", 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/round_sequencer.md
Name: round_sequencer

Overview:
Game-round controller that sequences the flag manager and the play datapath. It runs the round state machine: attract, ready, play, level clear, death and game over. It resets the flag manager at the start of each new level, scores collected flags by watching the flag display mask, awards the level-clear bonus, and tracks level and lives. It sits between the top-level game logic and the flag manager, car and fuel blocks, and drives their enable and reset strobes.

Parameters:
NUM_FLAGS, 5, width of the flag display mask
START_LIVES, 3, lives loaded at game start (1..3)
READY_FRAMES, 120, frame ticks spent in READY before play begins
CLEAR_FRAMES, 90, frame ticks spent in CLEAR
DEATH_FRAMES, 60, frame ticks spent in DEATH
OVER_FRAMES, 180, frame ticks spent in OVER
FLAG_POINTS, 100, base points per flag; scaled by (level+1)
CLEAR_BONUS, 1000, points added on entering CLEAR
SCORE_W, 16, score width
MAX_LEVEL, 15, level saturation value

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
frame_tick  in  1  one-Clk pulse per video frame
start_btn  in  1  level-sensitive start request
flagDisplay  in  NUM_FLAGS  from flag manager; 1 = flag still on field
crash  in  1  car collided with enemy or rock (level)
fuel_empty  in  1  fuel exhausted (level)
flagReset  out  1  one-Clk pulse that resets the flag manager
play_enable  out  1  high only in PLAY; gates car, enemy and fuel motion
state  out  3  ATTRACT=0, READY=1, PLAY=2, CLEAR=3, DEATH=4, OVER=5
level  out  4  current level, 0-based
lives  out  2  remaining lives
score  out  SCORE_W  accumulated score, binary
game_over  out  1  high in OVER

Behaviour:
- Reset (asynchronous): state=ATTRACT, score=0, level=0, lives=START_LIVES, flagReset=0, play_enable=0, game_over=0, frame counter=0, prev-flag register = all ones.
- All outputs are registered. State changes take effect in the cycle after the qualifying input is sampled.
- Frame counter: 8 bits, cleared on every state entry, incremented on each frame_tick. A timed state exits on the cycle when frame_tick arrives with counter = N-1, where N is that state's *_FRAMES value. The exit therefore happens on the N-th tick after entry.
- ATTRACT: if start_btn=1 -> READY. In the same edge: score=0, level=0, lives=START_LIVES, flagReset pulses for one cycle.
- READY: after READY_FRAMES ticks -> PLAY.
- PLAY: play_enable=1.
  - If flagDisplay == 0 -> CLEAR. This takes priority over crash and fuel_empty in the same cycle.
  - Else if crash or fuel_empty -> DEATH.
- Flag scoring:
  - fall = prev & ~flagDisplay; prev is registered every cycle in every state.
  - In PLAY only: score += popcount(fall) * FLAG_POINTS * (level+1), registered one cycle after the mask changes.
  - The edge that clears the last flag is scored in the same cycle as the move to CLEAR.
  - Falls outside PLAY are ignored.
- Score arithmetic: computed at SCORE_W+8 bits, then saturated to 2^SCORE_W-1; the score never wraps.
- CLEAR: on entry, score += CLEAR_BONUS (saturating). If the last-flag score and the bonus occur on the same edge, both are added. After CLEAR_FRAMES ticks -> READY, with level = min(level+1, MAX_LEVEL) and a one-cycle flagReset pulse.
- DEATH: on exit after DEATH_FRAMES ticks, lives decrements.
  - If lives was 1 -> OVER, lives=0.
  - Otherwise -> READY with no flagReset, so collected flags stay collected.
- OVER: game_over=1; start_btn is ignored. After OVER_FRAMES ticks -> ATTRACT. Score is held for display.
- flagReset is high for exactly one cycle per new level and is never asserted in PLAY.
- A stuck start_btn in ATTRACT starts exactly one game; no retrigger occurs until the FSM returns to ATTRACT.
- Reset asserted mid-state returns the FSM to ATTRACT immediately, with no pending pulse.
- Invalid state encodings 6 and 7 go to ATTRACT on the next clock.

Test Plan:
- Reset, pulse start_btn, drive 120 frame_ticks -> flagReset pulses once after start; state goes 0->1->2 on the 120th tick; score=0, lives=3, level=0.
- In PLAY at level 0, drop flagDisplay 11111->11110 -> score=100 one cycle later. Then drop two bits in one cycle (11110->11000) -> score=300.
- Clear the last flag (00001->00000) while crash=1 in the same cycle -> state=CLEAR (not DEATH); score +100 +1000. After 90 ticks: state=READY, level=1, one flagReset pulse. At level 1 each flag is worth 200.
- From PLAY with flags 10101, assert fuel_empty -> DEATH; after 60 ticks lives 3->2, state=READY, no flagReset; flagDisplay falls during DEATH do not change score.
- Die with lives=1 -> OVER, game_over=1, lives=0; start_btn held in OVER is ignored; after 180 ticks -> ATTRACT with score retained.
- Preload score at 65400 and clear a flag at level 3 (400 pts) -> score=65535, saturated. Assert Reset mid-CLEAR -> ATTRACT immediately with score=0.
